// File: rtl/vedic_pipe_mult.sv
// Pipelined Urdhva-Tiryagbhyam multiplier: registered 2x2 tiles, then one shift-add combine stage per recursion level.
// Define VEDIC_SIGNED_EN for two's-complement a/b/c (adds a sign pipeline and a final conditional-negate stage).
module vedic_pipe_mult #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] c,
  output logic               busy
);
  localparam int LEVELS = $clog2(WIDTH);

  if (WIDTH < 2 || WIDTH > 64 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("vedic_pipe_mult: WIDTH must be a power of two in 2..64");
  end

  logic [LEVELS:0]   vld;
  logic [LEVELS+1:1] rdy;
  logic [WIDTH-1:0]  a_op;
  logic [WIDTH-1:0]  b_op;

  assign vld[0]   = in_valid;
  assign in_ready = rdy[1];

`ifdef VEDIC_SIGNED_EN
  logic [LEVELS:0] sgn;

  // -2^(W-1) negates to itself; read as unsigned that bit pattern is exactly its magnitude
  assign a_op   = a[WIDTH-1] ? -a : a;
  assign b_op   = b[WIDTH-1] ? -b : b;
  assign sgn[0] = a[WIDTH-1] ^ b[WIDTH-1];
`else
  assign a_op = a;
  assign b_op = b;
`endif

  for (genvar gl = 1; gl <= LEVELS; gl++) begin : lvl
    localparam int BS = 1 << gl;
    localparam int N  = WIDTH >> gl;
    localparam int PW = 2 * BS;

    logic [N*N*PW-1:0] d_next;
    logic [N*N*PW-1:0] d_q;
    logic              v_q;

    if (gl == 1) begin : g_tiles
      for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
          logic [1:0] x;
          logic [1:0] y;
          logic       t_mid0;
          logic       t_mid1;
          logic       c_mid;
          logic       t_hi;

          assign x      = a_op[2*gi +: 2];
          assign y      = b_op[2*gj +: 2];
          assign t_mid0 = x[1] & y[0];
          assign t_mid1 = x[0] & y[1];
          assign c_mid  = t_mid0 & t_mid1;
          assign t_hi   = x[1] & y[1];
          assign d_next[(gi*N+gj)*4 +: 4] =
            {t_hi & c_mid, t_hi ^ c_mid, t_mid0 ^ t_mid1, x[0] & y[0]};
        end
      end
    end else begin : g_combine
      localparam int NP = 2 * N;
      localparam int HB = BS / 2;

      for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
          logic [PW-1:0] ll;
          logic [PW-1:0] hl;
          logic [PW-1:0] lh;
          logic [PW-1:0] hh;

          // sub-products are indexed (a-block, b-block) in the previous level's flat vector
          assign ll = {{BS{1'b0}}, lvl[gl-1].d_q[((2*gi)*NP   + 2*gj)  *BS +: BS]};
          assign hl = {{BS{1'b0}}, lvl[gl-1].d_q[((2*gi+1)*NP + 2*gj)  *BS +: BS]};
          assign lh = {{BS{1'b0}}, lvl[gl-1].d_q[((2*gi)*NP   + 2*gj+1)*BS +: BS]};
          assign hh = {{BS{1'b0}}, lvl[gl-1].d_q[((2*gi+1)*NP + 2*gj+1)*BS +: BS]};
          assign d_next[(gi*N+gj)*PW +: PW] = ll + ((hl + lh) << HB) + (hh << BS);
        end
      end
    end

    assign vld[gl] = v_q;
    assign rdy[gl] = !v_q || rdy[gl+1];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q <= 1'b0;
        d_q <= '0;
      end else if (flush) begin
        v_q <= 1'b0;
      end else if (rdy[gl]) begin
        v_q <= vld[gl-1];
        if (vld[gl-1]) d_q <= d_next;
      end
    end

`ifdef VEDIC_SIGNED_EN
    logic s_q;

    assign sgn[gl] = s_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s_q <= 1'b0;
      end else if (!flush && rdy[gl] && vld[gl-1]) begin
        s_q <= sgn[gl-1];
      end
    end
`endif
  end

`ifdef VEDIC_SIGNED_EN
  logic               o_v;
  logic [2*WIDTH-1:0] o_c;
  logic [2*WIDTH-1:0] prod;

  assign prod           = lvl[LEVELS].d_q;
  assign rdy[LEVELS+1]  = !o_v || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_v <= 1'b0;
      o_c <= '0;
    end else if (flush) begin
      o_v <= 1'b0;
    end else if (rdy[LEVELS+1]) begin
      o_v <= vld[LEVELS];
      if (vld[LEVELS]) o_c <= sgn[LEVELS] ? -prod : prod;
    end
  end

  assign out_valid = o_v;
  assign c         = o_c;
  assign busy      = (|vld[LEVELS:1]) || o_v;
`else
  assign rdy[LEVELS+1] = out_ready;
  assign out_valid     = vld[LEVELS];
  assign c             = lvl[LEVELS].d_q;
  assign busy          = |vld[LEVELS:1];
`endif

endmodule

// File: tb/tb_vedic_pipe_mult.sv
// Scoreboard bench for vedic_pipe_mult (WIDTH=16); directed vectors plus streaming, backpressure, flush and reset.
module tb_vedic_pipe_mult;
  localparam int W = 16;
`ifdef VEDIC_SIGNED_EN
  localparam int LAT = 5;
  localparam logic [W-1:0]   DA [8] = '{16'hFFFE, 16'h8000, 16'hFFFF, 16'h8000,
                                        16'h7FFF, 16'h0000, 16'h0003, 16'h0100};
  localparam logic [W-1:0]   DB [8] = '{16'h0003, 16'h8000, 16'hFFFF, 16'h0001,
                                        16'h7FFF, 16'hABCD, 16'hFFFB, 16'hFF00};
  localparam logic [2*W-1:0] DE [8] = '{32'hFFFFFFFA, 32'h40000000, 32'h00000001, 32'hFFFF8000,
                                        32'h3FFF0001, 32'h00000000, 32'hFFFFFFF1, 32'hFFFF0000};
`else
  localparam int LAT = 4;
  localparam logic [W-1:0]   DA [8] = '{16'h1234, 16'hFFFF, 16'h0000, 16'hABCD,
                                        16'h0001, 16'h00FF, 16'h8000, 16'hFFFF};
  localparam logic [W-1:0]   DB [8] = '{16'h5678, 16'hFFFF, 16'hABCD, 16'h0000,
                                        16'hABCD, 16'h00FF, 16'h0002, 16'h0002};
  localparam logic [2*W-1:0] DE [8] = '{32'h06260060, 32'hFFFE0001, 32'h00000000, 32'h00000000,
                                        32'h0000ABCD, 32'h0000FE01, 32'h00010000, 32'h0001FFFE};
`endif

  logic           clk = 1'b0;
  logic           rst, flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [W-1:0]   a, b;
  logic [2*W-1:0] c;

  int             errors = 0;
  int             checks = 0;
  int             accepts = 0;
  int             cyc_cnt = 0;
  logic [2*W-1:0] sb [$];

  vedic_pipe_mult #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .c(c), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef VEDIC_SIGNED_EN
    logic signed [2*W-1:0] sx, sy;
    sx = $signed(x);
    sy = $signed(y);
    return sx * sy;
`else
    logic [2*W-1:0] ux, uy;
    ux = x;
    uy = y;
    return ux * uy;
`endif
  endfunction

  // Called at a falling edge; returns at the falling edge after the handshake.
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic [2*W-1:0] e);
    int n = 0;
    in_valid = 1'b1;
    a = x;
    b = y;
    #1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", n);
    end else begin
      sb.push_back(e);
      accepts++;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_rand();
    logic [W-1:0] x, y;
    x = W'($urandom_range(0, 65535));
    y = W'($urandom_range(0, 65535));
    send(x, y, ref_mul(x, y));
  endtask

  task automatic single_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic [2*W-1:0] e);
    send(x, y, e);
    for (int cyc = 1; cyc <= LAT; cyc++) begin
      #1;
      chk("latency_valid", out_valid, cyc == LAT);
      if (cyc == LAT) chk("single_c", c, e);
      @(negedge clk);
    end
    #1;
    chk("idle_busy", busy, 1'b0);
    @(negedge clk);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", sb.size(), 0);
  endtask

  // Monitor: pops the scoreboard on every output handshake, checks hold-stability while stalled.
  logic           prev_stall = 1'b0;
  logic [2*W-1:0] prev_c = '0;
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst || flush) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("stall_valid", out_valid, 1'b1);
          chk("stall_c", c, prev_c);
        end
        prev_stall = out_valid && !out_ready;
        prev_c     = c;
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: got 0x%0h with no product pending", c);
          end else begin
            chk("product", c, sb.pop_front());
          end
        end
      end
    end
  end

  logic [2*W-1:0] hold_c;
  int             t0;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_c", c, '0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("reset_in_ready", in_ready, 1'b1);
    @(negedge clk);

    single_op(DA[0], DB[0], DE[0]);

    // back-to-back stream: directed table then random pairs
    t0 = cyc_cnt;
    for (int i = 0; i < 8; i++) send(DA[i], DB[i], DE[i]);
    for (int i = 0; i < 56; i++) send_rand();
    chk("stream_cycles", cyc_cnt - t0, 64);
    wait_drain();
    @(negedge clk);

    // backpressure: 10 stalled cycles with continuous input
    out_ready = 1'b0;
    accepts = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) send_rand();
      end
      begin
        repeat (10) @(negedge clk);
        #1;
        chk("bp_in_ready", in_ready, 1'b0);
        chk("bp_accepts", accepts, LAT);
        chk("bp_out_valid", out_valid, 1'b1);
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    wait_drain();
    chk("bp_total", accepts, 8);
    @(negedge clk);

    // flush with a simultaneous accepted input
    out_ready = 1'b0;
    for (int i = 0; i < LAT - 1; i++) send(W'(i + 3), 16'h0007, ref_mul(W'(i + 3), 16'h0007));
    flush = 1'b1; in_valid = 1'b1; a = 16'h7777; b = 16'h0003;
    #1;
    chk("flush_in_ready", in_ready, 1'b1);
    chk("flush_busy_before", busy, 1'b1);
    hold_c = c;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    sb.delete();
    #1;
    chk("flush_out_valid", out_valid, 1'b0);
    chk("flush_busy", busy, 1'b0);
    chk("flush_c_hold", c, hold_c);
    @(negedge clk);
    out_ready = 1'b1;
    single_op(16'h0101, 16'h0101, 32'h00010201);

    // asynchronous reset between edges while results are in flight
    for (int i = 0; i <= LAT; i++) send_rand();
    #3;
    chk("pre_reset_valid", out_valid, 1'b1);
    rst = 1'b1;
    #1;
    chk("async_out_valid", out_valid, 1'b0);
    chk("async_busy", busy, 1'b0);
    chk("async_c", c, '0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_reset_in_ready", in_ready, 1'b1);
    repeat (8) begin
      @(negedge clk);
      #1;
      chk("no_stale_out", out_valid, 1'b0);
    end
    @(negedge clk);
    single_op(DA[1], DB[1], DE[1]);

    wait_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
